axi4stream_output_serializer: RTL

Downstream counterpart of the AXI4-Stream input buffer. It accepts one wide parallel word per handshake and emits it as a sequence of narrow AXI4-Stream beats, least-significant slice first, asserting `tlast` on the final, partially-filled beat. It sits between the upscaler's wide-word datapath and any narrow AXI4-Stream consumer, such as the output FIFO or the HDMI TX path. It is the exact inverse of the input buffer's packing, so a round trip through both is lossless.

---
 rtl/axi4stream_output_serializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi4stream_output_serializer.sv
// rtl/axi4stream_output_serializer.sv - wide parallel word to narrow AXI4-Stream beat serializer
//
// Purpose:
//   Accepts one BUFFER_WIDTH-bit word per valid/ready handshake and emits it as
//   NUM_BEATS AXI_WIDTH-bit stream beats, least-significant slice first. The
//   final beat carries tlast and has the bits above LAST_PACKET_WIDTH-1 forced
//   to zero, so it is the exact inverse of the input buffer's packing.
//
// Ports:
//   aclk      in   single clock, rising edge
//   areset    in   asynchronous active-low reset
//   myBuffer  in   [BUFFER_WIDTH-1:0] parallel word, sampled on the handshake edge
//   valid     in   myBuffer holds a word
//   ready     out  a word can be accepted this cycle
//   tdata     out  [AXI_WIDTH-1:0] stream data
//   tvalid    out  tdata/tlast valid (registered)
//   tlast     out  final beat of the current word
//   tready    in   consumer accepts the beat
//   busy      out  a word is in flight or held
//
// Configuration:
//   AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN - when defined, adds a one-word
//   holding register so back-to-back words stream with no idle bubble.

module axi4stream_output_serializer #(
  parameter int AXI_WIDTH    = 8,
  parameter int BUFFER_WIDTH = 35
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [BUFFER_WIDTH-1:0] myBuffer,
  input  logic                    valid,
  output logic                    ready,
  output logic [AXI_WIDTH-1:0]    tdata,
  output logic                    tvalid,
  output logic                    tlast,
  input  logic                    tready,
  output logic                    busy
);

  localparam int NUM_BEATS         = (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
  localparam int LAST_PACKET_WIDTH = BUFFER_WIDTH - (NUM_BEATS - 1) * AXI_WIDTH;
  localparam int CNT_W             = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(NUM_BEATS - 1);
  // Keeps only the LAST_PACKET_WIDTH valid bits of the final beat.
  localparam logic [AXI_WIDTH-1:0] LAST_MASK = {AXI_WIDTH{1'b1}} >> (AXI_WIDTH - LAST_PACKET_WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [BUFFER_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  // Low until the first edge after reset release, so ready stays 0 in reset.
  logic                    alive_q;

`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
  logic [BUFFER_WIDTH-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
`endif

  logic                 in_hs;
  logic                 beat_hs;
  logic                 last_beat;
  logic [AXI_WIDTH-1:0] low_slice;

  assign last_beat = (state_q == S_SEND) && (cnt_q == LAST_CNT);
  assign in_hs     = valid && ready;
  assign beat_hs   = (state_q == S_SEND) && tready;
  // Truncates a wide word, zero-extends when the word is narrower than a beat.
  assign low_slice = AXI_WIDTH'(shreg_q);

`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
  assign ready = alive_q && !hold_full_q;
  assign busy  = (state_q == S_SEND) || hold_full_q;
`else
  assign ready = alive_q && (state_q == S_IDLE);
  assign busy  = (state_q == S_SEND);
`endif

  assign tvalid = (state_q == S_SEND);
  assign tlast  = last_beat;
  assign tdata  = tvalid ? (low_slice & (last_beat ? LAST_MASK : {AXI_WIDTH{1'b1}}))
                         : {AXI_WIDTH{1'b0}};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_hs) begin
          shreg_d = myBuffer;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      default: begin
        if (beat_hs) begin
          if (!last_beat) begin
            shreg_d = shreg_q >> AXI_WIDTH;
            cnt_d   = cnt_q + 1'b1;
          end else begin
`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
            if (hold_full_q) begin
              shreg_d     = hold_q;
              cnt_d       = '0;
              hold_full_d = 1'b0;
            end else if (in_hs) begin
              // Same-cycle input goes straight into the shifter.
              shreg_d = myBuffer;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end
`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
        // Any other accept during SEND parks the word; ready=0 when hold is full.
        if (in_hs && !(beat_hs && last_beat && !hold_full_q)) begin
          hold_d      = myBuffer;
          hold_full_d = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      alive_q <= 1'b1;
`ifdef AXI4STREAM_OUTPUT_SERIALIZER_PREFETCH_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

endmodule
